// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants and types for the decode control stage:
//                primary opcodes, ALU operation codes, control-bundle bit
//                positions and the combinational decode result record.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 3;
    localparam int CTRL_W  = 10;

    // Primary opcodes recognised by the decoder
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_MUL   = 6'b011100;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_XOR   = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_MUL   = 3'b111;

    // Bit positions inside the control bundle
    localparam int CTRL_RE       = 9;
    localparam int CTRL_WB       = 8;
    localparam int CTRL_EQ       = 7;
    localparam int CTRL_JUMP     = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic [CTRL_W-1:0]  ctrl;
        logic               illegal;
        logic               is_mul;
    } decode_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_ctrl_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_stage_if
//  Description : Handshake bundle for the decode control stage.
//                master : upstream/downstream environment (drives flush,
//                         in_valid, instr, out_ready)
//                slave  : the decode stage (drives in_ready, out_valid,
//                         ctrl, aluop, illegal, mul_busy)
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_ctrl_stage_if #(
    parameter int DATA_W = 32
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          instr;
    logic                       out_valid;
    logic                       out_ready;
    logic [decode_pkg::CTRL_W-1:0]  ctrl;
    logic [decode_pkg::ALUOP_W-1:0] aluop;
    logic                       illegal;
    logic                       mul_busy;

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, ctrl, aluop, illegal, mul_busy
    );

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, ctrl, aluop, illegal, mul_busy
    );
endinterface : decode_ctrl_stage_if
`default_nettype wire

// File: rtl/opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_decode
//  Description : Pure combinational primary-opcode decoder.
//  Ports       : op  (in)  6-bit primary opcode
//                dec (out) {aluop, ctrl, illegal, is_mul}
//  Revision    : 1.0  initial release
// ============================================================================
module opcode_decode
    import decode_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output decode_t         dec
);

    always_comb begin
        dec         = '0;
        dec.aluop   = ALU_ADD;
        dec.is_mul  = (op == OP_MUL);
        case (op)
            OP_RTYPE, OP_MUL: begin
                dec.aluop                = (op == OP_MUL) ? ALU_MUL : ALU_FUNCT;
                dec.ctrl[CTRL_REGWRITE]  = 1'b1;
                dec.ctrl[CTRL_REGDST]    = 1'b1;
            end
            OP_LB, OP_LW: begin
                // lb additionally flags a byte-wide access
                dec.ctrl[CTRL_WB]        = (op == OP_LB);
                dec.ctrl[CTRL_REGWRITE]  = 1'b1;
                dec.ctrl[CTRL_ALUSRC]    = 1'b1;
                dec.ctrl[CTRL_MEMTOREG]  = 1'b1;
            end
            OP_SB, OP_SW: begin
                dec.ctrl[CTRL_WB]        = (op == OP_SB);
                dec.ctrl[CTRL_ALUSRC]    = 1'b1;
                dec.ctrl[CTRL_MEMWRITE]  = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGTZ: begin
                dec.aluop                = ALU_SUB;
                dec.ctrl[CTRL_EQ]        = (op == OP_BEQ);
                dec.ctrl[CTRL_BRANCH]    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_XORI: begin
                case (op)
                    OP_ANDI: dec.aluop   = ALU_AND;
                    OP_ORI:  dec.aluop   = ALU_OR;
                    OP_LUI:  dec.aluop   = ALU_LUI;
                    OP_XORI: dec.aluop   = ALU_XOR;
                    default: dec.aluop   = ALU_ADD;
                endcase
                dec.ctrl[CTRL_REGWRITE]  = 1'b1;
                dec.ctrl[CTRL_ALUSRC]    = 1'b1;
            end
            OP_J, OP_JAL: begin
                // jal links: return-address write into the register file
                dec.ctrl[CTRL_RE]        = (op == OP_JAL);
                dec.ctrl[CTRL_JUMP]      = 1'b1;
                dec.ctrl[CTRL_REGWRITE]  = (op == OP_JAL);
            end
            default: begin
                dec.illegal              = 1'b1;
            end
        endcase
    end

endmodule : opcode_decode
`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_stage
//  Description : Registered instruction-decode control stage between IF/ID
//                and ID/EX. Decodes the primary opcode into a registered
//                control bundle and aluop behind a valid/ready handshake,
//                holds issue for MUL_LAT cycles after a mul and flags
//                illegal opcodes.
//  Ports       : clk   (in)  rising-edge clock
//                rst_n (in)  synchronous reset, active low
//                bus   (slave modport of decode_ctrl_stage_if)
//                  flush, in_valid, instr, out_ready  -> inputs
//                  in_ready, out_valid, ctrl, aluop,
//                  illegal, mul_busy                  -> outputs
//  Revision    : 1.0  initial release
// ============================================================================
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    decode_ctrl_stage_if.slave  bus
);

    // The mul itself occupies the accept cycle, so only MUL_LAT-1 extra
    // cycles of hold are needed.
    localparam logic [CNT_W-1:0] C_HOLD_INIT = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_out_valid;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_illegal;

    decode_t            w_dec;
    logic [OP_W-1:0]    w_op;
    logic               w_busy;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_unused_instr;

    assign w_op           = bus.instr[DATA_W-1 -: OP_W];
    assign w_unused_instr = ^bus.instr[DATA_W-OP_W-1:0];

    opcode_decode u_opcode_decode (
        .op  (w_op),
        .dec (w_dec)
    );

    assign w_busy     = (r_hold_cnt != '0);
    assign w_in_ready = rst_n & ~w_busy & (~r_out_valid | bus.out_ready);
    // A flush drops whatever is presented in the same cycle
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_aluop     <= '0;
            r_illegal   <= 1'b0;
            r_hold_cnt  <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_aluop     <= '0;
            r_illegal   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_ctrl      <= w_dec.ctrl;
                r_aluop     <= w_dec.aluop;
                r_illegal   <= w_dec.illegal;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Accept is impossible while busy, so load and decrement never
            // compete for the counter.
            if (w_accept && w_dec.is_mul) begin
                r_hold_cnt <= C_HOLD_INIT;
            end else if (w_busy) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ctrl      = r_ctrl;
    assign bus.aluop     = r_aluop;
    assign bus.illegal   = r_illegal;
    assign bus.mul_busy  = w_busy;

endmodule : decode_ctrl_stage
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_ctrl_stage
//  Description : Self-checking bench for decode_ctrl_stage. A cycle-level
//                behavioural model (opcode table lookup plus a "release edge"
//                for the mul hold) predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_ctrl_stage;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.DATA_W(DATA_W)) bus ();

    decode_ctrl_stage #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Decode table transcribed directly from the opcode list
    logic [5:0] t_op   [17] = '{6'b000000, 6'b011100, 6'b100000, 6'b100011, 6'b101000,
                                6'b101011, 6'b000100, 6'b000101, 6'b000111, 6'b001000,
                                6'b001001, 6'b000010, 6'b000011, 6'b001100, 6'b001101,
                                6'b001111, 6'b001110};
    logic [2:0] t_alu  [17] = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b000,
                                3'b000, 3'b001, 3'b001, 3'b001, 3'b000,
                                3'b000, 3'b000, 3'b000, 3'b011, 3'b101,
                                3'b100, 3'b110};
    logic [9:0] t_ctrl [17] = '{10'b0000110000, 10'b0000110000, 10'b0100101001, 10'b0000101001,
                                10'b0100001010, 10'b0000001010, 10'b0010000100, 10'b0000000100,
                                10'b0000000100, 10'b0000101000, 10'b0000101000, 10'b0001000000,
                                10'b1001100000, 10'b0000101000, 10'b0000101000, 10'b0000101000,
                                10'b0000101000};

    // Behavioural model state
    logic       m_valid, m_illegal;
    logic [9:0] m_ctrl;
    logic [2:0] m_aluop;
    int         m_edge;     // number of clock edges completed
    int         m_release;  // first edge index at which an accept is allowed again
    logic       exp_ir, seen_ir;

    function automatic void ref_decode(input logic [5:0] op, output logic [2:0] a,
                                       output logic [9:0] c, output logic ill, output logic mul);
        a = 3'b000; c = '0; ill = 1'b1; mul = (op == 6'b011100);
        for (int k = 0; k < 17; k++) begin
            if (t_op[k] == op) begin
                a = t_alu[k]; c = t_ctrl[k]; ill = 1'b0;
            end
        end
    endfunction

    function automatic logic m_busy();
        return (m_edge + 1) < m_release;
    endfunction

    // Drive one cycle (starting just after a falling edge), advance the model,
    // return just after the next falling edge.
    task automatic step(input logic rn, input logic fl, input logic iv,
                        input logic [31:0] ins, input logic ordy);
        logic [2:0] a; logic [9:0] c; logic ill, mul;
        rst_n        = rn;
        bus.flush    = fl;
        bus.in_valid = iv;
        bus.instr    = ins;
        bus.out_ready = ordy;
        #1;
        seen_ir = bus.in_ready;
        exp_ir  = rn && !m_busy() && (!m_valid || ordy);
        @(posedge clk);
        m_edge++;
        if (!rn) begin
            m_valid = 0; m_ctrl = '0; m_aluop = '0; m_illegal = 0; m_release = 0;
        end else if (fl) begin
            m_valid = 0; m_illegal = 0; m_release = 0;
        end else if (iv && exp_ir) begin
            ref_decode(ins[31:26], a, c, ill, mul);
            m_valid = 1; m_aluop = a; m_ctrl = c; m_illegal = ill;
            if (mul) m_release = m_edge + MUL_LAT;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_MUL  = 32'h70221002;
    localparam logic [31:0] I_ADDI = 32'h20210005;
    localparam logic [31:0] I_SW   = 32'hAC220008;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1, I_LW, 1'b1);
        step(1'b0, 1'b0, 1'b1, I_MUL, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.ctrl !== 10'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", bus.ctrl); end
        total++; if (bus.aluop !== 3'b000) begin bad++; $display("FAIL reset_aluop: got %b want 000", bus.aluop); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
        total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL reset_mul_busy: got %b want 0", bus.mul_busy); end
        total++; if (seen_ir !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", seen_ir); end
    endtask

    task automatic test_lw();
        step(1'b1, 1'b0, 1'b1, I_LW, 1'b1);
        total++; if (seen_ir !== 1'b1) begin bad++; $display("FAIL lw_in_ready: got %b want 1", seen_ir); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lw_out_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.ctrl !== 10'b0000101001) begin bad++; $display("FAIL lw_ctrl: got %b want 0000101001", bus.ctrl); end
        total++; if (bus.aluop !== 3'b000) begin bad++; $display("FAIL lw_aluop: got %b want 000", bus.aluop); end
        step(1'b1, 1'b0, 1'b0, I_LW, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lw_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b1, I_LW, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, I_SW, 1'b0);
            total++; if (seen_ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, seen_ir); end
            total++; if (bus.out_valid !== 1'b1 || bus.ctrl !== 10'b0000101001) begin
                bad++; $display("FAIL stall_hold[%0d]: got v=%b ctrl=%b want v=1 ctrl=0000101001", i, bus.out_valid, bus.ctrl); end
        end
        step(1'b1, 1'b0, 1'b0, I_SW, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_consume: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_mul_hold();
        int n = 0, zeros = 0;
        logic done = 0;
        step(1'b1, 1'b0, 1'b1, I_MUL, 1'b1);
        total++; if (bus.aluop !== 3'b111 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL mul_out: got v=%b aluop=%b want v=1 aluop=111", bus.out_valid, bus.aluop); end
        total++; if (bus.mul_busy !== 1'b1) begin bad++; $display("FAIL mul_busy: got %b want 1", bus.mul_busy); end
        while (!done && n < 10) begin
            step(1'b1, 1'b0, 1'b1, I_ADDI, 1'b1);
            n++;
            if (!seen_ir) zeros++;
            if (bus.out_valid && bus.aluop == 3'b000 && bus.ctrl == 10'b0000101000) done = 1;
        end
        total++; if (n !== MUL_LAT) begin bad++; $display("FAIL mul_addi_latency: got %0d want %0d", n, MUL_LAT); end
        total++; if (zeros !== MUL_LAT - 1) begin bad++; $display("FAIL mul_stall_cycles: got %0d want %0d", zeros, MUL_LAT - 1); end
        step(1'b1, 1'b0, 1'b0, I_ADDI, 1'b1);
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b0, 1'b1, I_ILL, 1'b1);
        total++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1) begin
            bad++; $display("FAIL illegal_flag: got v=%b ill=%b want v=1 ill=1", bus.out_valid, bus.illegal); end
        total++; if (bus.ctrl !== 10'b0 || bus.aluop !== 3'b000) begin
            bad++; $display("FAIL illegal_fields: got ctrl=%b aluop=%b want 0/000", bus.ctrl, bus.aluop); end
        total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL illegal_busy: got %b want 0", bus.mul_busy); end
        step(1'b1, 1'b0, 1'b1, I_ADDI, 1'b1);
        total++; if (seen_ir !== 1'b1 || bus.illegal !== 1'b0) begin
            bad++; $display("FAIL illegal_next: got ir=%b ill=%b want ir=1 ill=0", seen_ir, bus.illegal); end
        step(1'b1, 1'b0, 1'b0, I_ADDI, 1'b1);
    endtask

    task automatic test_flush();
        step(1'b1, 1'b0, 1'b1, I_MUL, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.mul_busy !== 1'b1) begin
            bad++; $display("FAIL flush_setup: got v=%b busy=%b want 1/1", bus.out_valid, bus.mul_busy); end
        step(1'b1, 1'b1, 1'b1, I_LW, 1'b0);
        total++; if (bus.out_valid !== 1'b0 || bus.mul_busy !== 1'b0) begin
            bad++; $display("FAIL flush_clear: got v=%b busy=%b want 0/0", bus.out_valid, bus.mul_busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        step(1'b1, 1'b1, 1'b1, I_LW, 1'b1);
        total++; if (seen_ir !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_drop: got ir=%b v=%b want ir=1 v=0", seen_ir, bus.out_valid); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 17; i++) begin
            logic [31:0] ins;
            int tries = 0;
            logic acc = 0;
            ins = {t_op[i], 26'($urandom())};
            while (!acc && tries < 8) begin
                step(1'b1, 1'b0, 1'b1, ins, 1'b1);
                acc = exp_ir;
                tries++;
                total++; if (seen_ir !== exp_ir) begin bad++; $display("FAIL sweep_in_ready[%0d]: got %b want %b", i, seen_ir, exp_ir); end
            end
            total++; if (!acc || bus.out_valid !== 1'b1 || bus.ctrl !== t_ctrl[i] || bus.aluop !== t_alu[i] || bus.illegal !== 1'b0) begin
                bad++; $display("FAIL sweep_op[%0d]: got v=%b ctrl=%b alu=%b ill=%b want v=1 ctrl=%b alu=%b ill=0",
                                i, bus.out_valid, bus.ctrl, bus.aluop, bus.illegal, t_ctrl[i], t_alu[i]); end
        end
        step(1'b1, 1'b0, 1'b0, I_LW, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            if ($urandom_range(3) == 0) ins = $urandom();
            else ins = {t_op[$urandom_range(16)], 26'($urandom())};
            step($urandom_range(39) != 0, $urandom_range(15) == 0, 1'($urandom()), ins, $urandom_range(3) != 0);
            total++; if (seen_ir !== exp_ir) begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, seen_ir, exp_ir); end
            total++; if (bus.out_valid !== m_valid || bus.mul_busy !== m_busy()) begin
                bad++; $display("FAIL rand_state[%0d]: got v=%b busy=%b want v=%b busy=%b", i, bus.out_valid, bus.mul_busy, m_valid, m_busy()); end
            if (m_valid) begin
                total++; if (bus.ctrl !== m_ctrl || bus.aluop !== m_aluop || bus.illegal !== m_illegal) begin
                    bad++; $display("FAIL rand_data[%0d]: got ctrl=%b alu=%b ill=%b want ctrl=%b alu=%b ill=%b",
                                    i, bus.ctrl, bus.aluop, bus.illegal, m_ctrl, m_aluop, m_illegal); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
        m_valid = 0; m_illegal = 0; m_ctrl = '0; m_aluop = '0; m_edge = 0; m_release = 0;
        exp_ir = 0; seen_ir = 0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_stall();
        test_mul_hold();
        test_illegal();
        test_flush();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decode_ctrl_stage
`default_nettype wire
